// File: rtl/psum_output_accumulator.sv
// Collects bottom-row partial sums of the systolic array, removes the column skew,
// accumulates rows across weight tiles and drains finished rows over valid/ready.
module psum_output_accumulator #(
  parameter int COLS                   = 4,
  parameter int ACCUMULATOR_DATA_WIDTH = 32,
  parameter int DEPTH                  = 16,
  parameter int TILE_WIDTH             = 8
) (
  input  logic                                   CLK,
  input  logic                                   SYNC_RST_N,
  input  logic                                   START,
  input  logic [$clog2(DEPTH+1)-1:0]             ROWS_CFG,
  input  logic [TILE_WIDTH-1:0]                  TILES_CFG,
  input  logic                                   VALID_IN,
  input  logic [COLS*ACCUMULATOR_DATA_WIDTH-1:0] PSUM_IN,
  output logic [COLS*ACCUMULATOR_DATA_WIDTH-1:0] OUT_DATA,
  output logic                                   OUT_VALID,
  input  logic                                   OUT_READY,
  output logic                                   BUSY,
  output logic                                   DONE,
  output logic                                   ERR
);
  localparam int W  = ACCUMULATOR_DATA_WIDTH;
  localparam int RW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = RW + TILE_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  function automatic logic signed [W-1:0] add_wrap(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
    return a + b;
  endfunction

  state_t                r_state, w_state_nxt;
  logic [RW-1:0]         r_rows;
  logic [TILE_WIDTH-1:0] r_tiles, r_tile_cnt;
  logic [CW-1:0]         r_in_cnt, w_total;
  logic [AW-1:0]         r_wr_ptr, r_rd_ptr;
  logic                  r_done, r_err;
  logic signed [W-1:0]   r_buf [DEPTH][COLS];
  logic signed [W-1:0]   w_aligned [COLS];
  logic                  w_vld_al, w_accept, w_drop, w_cfg_ok, w_start_ok, w_bad_start;
  logic                  w_wr_en, w_wr_last_row, w_wr_last, w_xfer, w_rd_last;

  assign w_total       = CW'(r_rows) * CW'(r_tiles);
  assign w_cfg_ok      = (ROWS_CFG != '0) && (TILES_CFG != '0);
  assign w_start_ok    = START && (r_state == S_IDLE) && w_cfg_ok;
  assign w_bad_start   = START && (r_state == S_IDLE) && !w_cfg_ok;
  assign w_accept      = VALID_IN && (r_state == S_ACCUM) && (r_in_cnt < w_total);
  assign w_drop        = VALID_IN && !w_accept;
  assign w_wr_en       = w_vld_al && (r_state == S_ACCUM);
  assign w_wr_last_row = (RW'(r_wr_ptr) == r_rows - RW'(1));
  assign w_wr_last     = w_wr_en && w_wr_last_row && (r_tile_cnt == r_tiles - TILE_WIDTH'(1));
  assign w_xfer        = (r_state == S_DRAIN) && OUT_READY;
  assign w_rd_last     = (RW'(r_rd_ptr) == r_rows - RW'(1));

  // Deskew stage: column c waits COLS-1-c cycles so a whole row lines up with column COLS-1
  for (genvar gc = 0; gc < COLS; gc++) begin : g_col
    localparam int D = COLS - 1 - gc;
    if (D == 0) begin : g_direct
      assign w_aligned[gc] = PSUM_IN[gc*W +: W];
    end else begin : g_dly
      logic signed [W-1:0] r_dly_p [D];
      always_ff @(posedge CLK) begin
        if (!SYNC_RST_N) begin
          for (int k = 0; k < D; k++) r_dly_p[k] <= '0;
        end else begin
          r_dly_p[0] <= PSUM_IN[gc*W +: W];
          for (int k = 1; k < D; k++) r_dly_p[k] <= r_dly_p[k-1];
        end
      end
      assign w_aligned[gc] = r_dly_p[D-1];
    end
  end

  // Only accepted inputs enter the valid pipe, so dropped rows never reach the buffer
  if (COLS > 1) begin : g_vld
    logic [COLS-2:0] r_vld_p;
    always_ff @(posedge CLK) begin
      if (!SYNC_RST_N) begin
        r_vld_p <= '0;
      end else begin
        r_vld_p[0] <= w_accept;
        for (int k = 1; k < COLS - 1; k++) r_vld_p[k] <= r_vld_p[k-1];
      end
    end
    assign w_vld_al = r_vld_p[COLS-2];
  end else begin : g_vld_direct
    assign w_vld_al = w_accept;
  end

  always_ff @(posedge CLK) begin
    if (!SYNC_RST_N) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_wr_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_xfer && w_rd_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!SYNC_RST_N) begin
      r_rows     <= '0;
      r_tiles    <= '0;
      r_tile_cnt <= '0;
      r_in_cnt   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= w_xfer && w_rd_last;
      if (w_bad_start || w_drop) r_err <= 1'b1;
      else if (w_start_ok)       r_err <= 1'b0;
      if (w_start_ok) begin
        r_rows     <= ROWS_CFG;
        r_tiles    <= TILES_CFG;
        r_tile_cnt <= '0;
        r_in_cnt   <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_accept) r_in_cnt <= r_in_cnt + CW'(1);
        if (w_wr_en) begin
          if (w_wr_last_row) begin
            r_wr_ptr   <= '0;
            r_tile_cnt <= r_tile_cnt + TILE_WIDTH'(1);
          end else begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
          end
        end
        if (w_wr_last)   r_rd_ptr <= '0;
        else if (w_xfer) r_rd_ptr <= w_rd_last ? '0 : r_rd_ptr + AW'(1);
      end
    end
  end

  // Tile 0 overwrites the entry, so the buffer itself needs no reset
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      for (int c = 0; c < COLS; c++) begin
        r_buf[r_wr_ptr][c] <= (r_tile_cnt == '0) ? w_aligned[c]
                                                 : add_wrap(r_buf[r_wr_ptr][c], w_aligned[c]);
      end
    end
  end

  always_comb begin
    OUT_DATA = '0;
    if (r_state == S_DRAIN) begin
      for (int c = 0; c < COLS; c++) OUT_DATA[c*W +: W] = r_buf[r_rd_ptr][c];
    end
  end

  assign OUT_VALID = (r_state == S_DRAIN);
  assign BUSY      = (r_state != S_IDLE);
  assign DONE      = r_done;
  assign ERR       = r_err;

endmodule

// File: doc/psum_output_accumulator.md
# psum_output_accumulator

Downstream stage of the systolic PE array. It collects the partial sums leaving the bottom row of the array, one per column, and removes the diagonal column skew. It then accumulates results across successive weight tiles into a row buffer and drains the finished rows through a valid/ready output port. Each column value is the `PsumOut` of the last PE in that column.

## Interface
Parameters:
- COLS, 4: number of array columns (bottom-row PEs).
- ACCUMULATOR_DATA_WIDTH, 32: width of each column partial sum.
- DEPTH, 16: number of row entries in the accumulation buffer.
- TILE_WIDTH, 8: width of the tile-count configuration.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- SYNC_RST_N  in  1  synchronous, active-low reset; sampled on the rising edge of CLK.
- START  in  1  one-cycle job start; accepted only in IDLE.
- ROWS_CFG  in  $clog2(DEPTH+1)  rows per tile, legal range 1..DEPTH; sampled with START.
- TILES_CFG  in  TILE_WIDTH  tiles to accumulate, legal range 1..2^TILE_WIDTH-1; sampled with START.
- VALID_IN  in  1  qualifies the column-0 sum on this cycle.
- PSUM_IN  in  COLS*ACCUMULATOR_DATA_WIDTH  signed bottom-row sums; column c occupies bits [c*W +: W]. Column c arrives c cycles after column 0.
- OUT_DATA  out  COLS*ACCUMULATOR_DATA_WIDTH  accumulated row, packed the same way as PSUM_IN.
- OUT_VALID  out  1  OUT_DATA is valid.
- OUT_READY  in  1  consumer accepts OUT_DATA.
- BUSY  out  1  asserted whenever the state is not IDLE.
- DONE  out  1  one-cycle pulse when the job completes.
- ERR  out  1  sticky protocol error; cleared by an accepted START.

## Operation
- FSM states: IDLE, ACCUM, DRAIN.
- Deskew:
  - Column c is delayed by COLS-1-c register stages.
  - VALID_IN is delayed by COLS-1 stages, giving aligned_valid.
  - An aligned row appears COLS-1 cycles after its column-0 input.
- IDLE:
  - START with ROWS_CFG≥1 and TILES_CFG≥1 → ACCUM. This latches the configuration, clears wr_ptr, tile_cnt and in_cnt, and clears ERR.
  - START with a zero field → stay in IDLE and set ERR.
- ACCUM, input side:
  - A VALID_IN is accepted while in_cnt < ROWS_CFG*TILES_CFG; in_cnt increments.
  - Excess VALID_IN is dropped (not entered into the deskew pipe) and sets ERR.
- ACCUM, buffer side:
  - On aligned_valid with tile_cnt==0: buf[wr_ptr] = aligned row.
  - On aligned_valid otherwise: buf[wr_ptr] = buf[wr_ptr] + aligned row, per column.
  - wr_ptr increments; at ROWS_CFG-1 it wraps to 0 and tile_cnt increments.
- ACCUM exit: the aligned write of the last row of the last tile moves the FSM to DRAIN on the next edge, with rd_ptr = 0.
- DRAIN:
  - OUT_VALID = 1 and OUT_DATA = buf[rd_ptr].
  - On OUT_VALID && OUT_READY, rd_ptr increments.
  - The handshake on row ROWS_CFG-1 → IDLE, with DONE pulsed.
- VALID_IN in IDLE or DRAIN is dropped and sets ERR.
- START outside IDLE is ignored and does not set ERR.
- Arithmetic: signed two's-complement addition modulo 2^ACCUMULATOR_DATA_WIDTH per column; wrap-around, no saturation.

## Timing
- Reset values:
  - Outputs: OUT_VALID=0, OUT_DATA=0, BUSY=0, DONE=0, ERR=0.
  - Internal: FSM=IDLE; deskew registers, pointers and counters = 0.
  - Buffer contents are don't-care (tile 0 overwrites them).
- Reset mid-job: the next edge returns to IDLE, drops OUT_VALID and flushes in-flight deskew data. No DONE is pulsed.
- Latencies:
  - Column-0 input at cycle t → buffer updated at the edge ending cycle t+COLS-1.
  - Last aligned write in cycle t → DRAIN and OUT_VALID in cycle t+1.
- Handshake rules:
  - OUT_DATA and OUT_VALID stay stable while OUT_READY is low.
  - Back-to-back transfers run one row per cycle while OUT_READY is held high.
- DONE is asserted in the cycle after the final transfer, coincident with BUSY falling.
- Back-to-back rows: one row per cycle sustained, including a read-modify-write to the same entry on consecutive tiles when ROWS_CFG=1.

## Test plan
- Single tile, COLS=4:
  - Stimulus: START with ROWS_CFG=2, TILES_CFG=1; skewed rows {1,2,3,4} and {5,6,7,8}; OUT_READY=1.
  - Response: OUT_DATA = {1,2,3,4} then {5,6,7,8}; DONE one cycle later; ERR=0.
- Accumulation:
  - Stimulus: ROWS_CFG=1, TILES_CFG=3; each tile drives all columns = 10, including -5 in column 2 for tile 2.
  - Response: OUT_DATA = {30,30,15,30}.
- Wrap-around:
  - Stimulus: TILES_CFG=2; column 0 = 0x7FFFFFFF then 1.
  - Response: column 0 out = 0x80000000.
- Backpressure:
  - Stimulus: ROWS_CFG=3; OUT_READY low for 5 cycles in DRAIN.
  - Response: OUT_VALID=1 and row 0 stable throughout; rows 1 and 2 follow on consecutive cycles once OUT_READY=1.
- Errors:
  - Stimulus: VALID_IN in IDLE; a 3rd row when ROWS_CFG*TILES_CFG=2; START with TILES_CFG=0.
  - Response: ERR=1 each time; buffer unchanged; FSM stays IDLE on the bad START; a valid START clears ERR.
- Reset mid-DRAIN:
  - Stimulus: SYNC_RST_N low for 1 cycle during DRAIN.
  - Response: next cycle OUT_VALID=0, BUSY=0, no DONE; a new job then completes correctly.
